pool2x2_stream: RTL and testbench

Parametrised 2x2/stride-2 pooling stage that follows the convolution engine. It accepts a raster stream of activations, LANES pixels per beat, and buffers one even row. It combines that row with the following odd row and emits one pooled beat per odd-row beat, with LANES/2 pixels per beat. Supports runtime max or average mode, signed or unsigned pixels, and ready/valid backpressure on both sides.

---
 rtl/pool2x2_stream.sv | 123 ++++++++++++
 tb/tb_pool2x2_stream.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool2x2_stream.sv
// 2x2 / stride-2 pooling stage: buffers one even row, combines it with the next odd row,
// and emits LANES/2 pooled pixels per odd-row beat (max or average, signed or unsigned).
module pool2x2_stream #(
    parameter int DW        = 8,
    parameter int LANES     = 4,
    parameter int ROW_BEATS = 4,
    parameter int ROWS      = 2,
    parameter int SIGNED    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*DW-1:0]          in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [(LANES/2)*DW-1:0]      out_data,
    output logic                         out_last,
    output logic                         frame_done
);

    localparam int OL = LANES / 2;
    localparam int CW = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic {ST_EVEN, ST_ODD} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_col;
    logic [RW-1:0]       r_row;
    logic                r_mode;
    logic [LANES*DW-1:0] r_buf [ROW_BEATS];

    logic                w_acc;
    logic                w_col_wrap;
    logic                w_row_wrap;
    logic [OL*DW-1:0]    w_pool;

    function automatic logic [DW+1:0] ext(input logic [DW-1:0] v);
        return (SIGNED != 0) ? {{2{v[DW-1]}}, v} : {2'b00, v};
    endfunction

    // Extended operands are compared as signed; zero-extension keeps unsigned values positive.
    function automatic logic [DW-1:0] pool_pix(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [DW-1:0] c, input logic [DW-1:0] d,
                                               input logic avg);
        logic signed [DW+1:0] ea, eb, ec, ed, m1, m2, mx, sum;
        ea  = $signed(ext(a));
        eb  = $signed(ext(b));
        ec  = $signed(ext(c));
        ed  = $signed(ext(d));
        m1  = (ea > eb) ? ea : eb;
        m2  = (ec > ed) ? ec : ed;
        mx  = (m1 > m2) ? m1 : m2;
        sum = ea + eb + ec + ed + (DW+2)'(2);
        // Logical and arithmetic shifts agree on the kept bits [DW+1:2].
        return avg ? sum[DW+1:2] : mx[DW-1:0];
    endfunction

    always_comb begin
        in_ready = (r_state == ST_EVEN) || !out_valid || out_ready;
    end

    assign w_acc      = in_valid && in_ready;
    assign w_col_wrap = (r_col == CW'(ROW_BEATS - 1));
    assign w_row_wrap = (r_row == RW'(ROWS - 1));

    always_comb begin
        w_pool = '0;
        for (int unsigned j = 0; j < OL; j++) begin
            w_pool[j*DW +: DW] = pool_pix(r_buf[r_col][(2*j)*DW +: DW],
                                          r_buf[r_col][(2*j+1)*DW +: DW],
                                          in_data[(2*j)*DW +: DW],
                                          in_data[(2*j+1)*DW +: DW],
                                          r_mode);
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc && r_state == ST_EVEN) begin
            r_buf[r_col] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_EVEN;
            r_col      <= '0;
            r_row      <= '0;
            r_mode     <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_valid && out_ready && out_last;

            if (w_acc) begin
                if (r_row == '0 && r_col == '0) begin
                    r_mode <= mode;
                end
                if (w_col_wrap) begin
                    r_col   <= '0;
                    r_row   <= w_row_wrap ? '0 : r_row + RW'(1);
                    r_state <= (r_state == ST_EVEN) ? ST_ODD : ST_EVEN;
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end

            if (w_acc && r_state == ST_ODD) begin
                out_valid <= 1'b1;
                out_data  <= w_pool;
                out_last  <= w_col_wrap && w_row_wrap;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Bench for pool2x2_stream: an unsigned and a signed instance share one input stream and are
// scored against an arithmetic reference model of 2x2 pooling.
module tb_pool2x2_stream;

    localparam int DW = 8;
    localparam int L  = 4;
    localparam int RB = 4;
    localparam int RS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready_u, out_valid_u, out_last_u, frame_done_u;
    logic [15:0] out_data_u;
    logic        in_ready_s, out_valid_s, out_last_s, frame_done_s;
    logic [15:0] out_data_s;

    always #5 clk = ~clk;

    pool2x2_stream #(.DW(DW), .LANES(L), .ROW_BEATS(RB), .ROWS(RS), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_data(in_data), .out_valid(out_valid_u), .out_ready(out_ready),
        .out_data(out_data_u), .out_last(out_last_u), .frame_done(frame_done_u));

    pool2x2_stream #(.DW(DW), .LANES(L), .ROW_BEATS(RB), .ROWS(RS), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .out_last(out_last_s), .frame_done(frame_done_s));

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [7:0]  fr [RS][RB*L];
    logic [16:0] q_u[$];
    logic [16:0] q_s[$];
    bit          fd_exp_u = 0;
    bit          fd_exp_s = 0;
    bit          bp_rand  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_pix(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] d,
                                           input logic avg, input bit sgn);
        int v[4];
        int mx, s, r;
        v[0] = sgn ? int'($signed(a)) : int'(a);
        v[1] = sgn ? int'($signed(b)) : int'(b);
        v[2] = sgn ? int'($signed(c)) : int'(c);
        v[3] = sgn ? int'($signed(d)) : int'(d);
        mx = v[0];
        for (int i = 1; i < 4; i++) if (v[i] > mx) mx = v[i];
        s = v[0] + v[1] + v[2] + v[3] + 2;
        r = avg ? (s >>> 2) : mx;
        return r[7:0];
    endfunction

    function automatic logic [31:0] pack_beat(input int r, input int c);
        logic [31:0] v;
        for (int k = 0; k < L; k++) v[k*8 +: 8] = fr[r][c*L+k];
        return v;
    endfunction

    task automatic expect_frame(input logic m);
        for (int rp = 0; rp < RS/2; rp++) begin
            for (int c = 0; c < RB; c++) begin
                logic [15:0] du, ds;
                logic        last;
                for (int j = 0; j < L/2; j++) begin
                    du[j*8 +: 8] = ref_pix(fr[2*rp][c*L+2*j], fr[2*rp][c*L+2*j+1],
                                           fr[2*rp+1][c*L+2*j], fr[2*rp+1][c*L+2*j+1], m, 0);
                    ds[j*8 +: 8] = ref_pix(fr[2*rp][c*L+2*j], fr[2*rp][c*L+2*j+1],
                                           fr[2*rp+1][c*L+2*j], fr[2*rp+1][c*L+2*j+1], m, 1);
                end
                last = (rp == RS/2 - 1) && (c == RB - 1);
                q_u.push_back({last, du});
                q_s.push_back({last, ds});
            end
        end
    endtask

    task automatic clear_frame();
        for (int r = 0; r < RS; r++) for (int p = 0; p < RB*L; p++) fr[r][p] = 8'h00;
    endtask

    task automatic rand_frame();
        for (int r = 0; r < RS; r++) for (int p = 0; p < RB*L; p++) fr[r][p] = 8'($urandom);
    endtask

    // Called at posedge+#1; returns at posedge+#1 after the beat has been accepted.
    task automatic send_beat(input logic [31:0] d, input logic m, output int waits);
        waits    = 0;
        in_valid = 1'b1;
        in_data  = d;
        mode     = m;
        forever begin
            if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_ready_u) break;
            waits++;
            if (waits > 200) begin
                check("in_ready_timeout", 32'(in_ready_u), 32'd1);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_range(input int first, input int count, input logic m, output int total);
        int w;
        total = 0;
        for (int b = first; b < first + count; b++) begin
            send_beat(pack_beat(b / RB, b % RB), m, w);
            total += w;
        end
    endtask

    task automatic run_frame(input logic m, input int chg, input logic m2);
        int w;
        expect_frame(m);
        for (int b = 0; b < RS*RB; b++) begin
            send_beat(pack_beat(b / RB, b % RB), (chg >= 0 && b >= chg) ? m2 : m, w);
        end
    endtask

    task automatic drain(input string tag);
        int g = 0;
        bp_rand   = 0;
        out_ready = 1'b1;
        while ((q_u.size() != 0 || q_s.size() != 0) && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        check({tag, "_pending_u"}, 32'(q_u.size()), 32'd0);
        check({tag, "_pending_s"}, 32'(q_s.size()), 32'd0);
    endtask

    // Scoreboard: a beat with valid & ready at this negedge handshakes on the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            q_u.delete();
            q_s.delete();
            fd_exp_u = 0;
            fd_exp_s = 0;
        end else begin
            check("frame_done_u", 32'(frame_done_u), 32'(fd_exp_u));
            check("frame_done_s", 32'(frame_done_s), 32'(fd_exp_s));
            fd_exp_u = 0;
            fd_exp_s = 0;
            if (out_valid_u && out_ready) begin
                if (q_u.size() == 0) check("spurious_u", 32'(out_valid_u), 32'd0);
                else begin
                    logic [16:0] e;
                    e = q_u.pop_front();
                    check("data_u", 32'(out_data_u), 32'(e[15:0]));
                    check("last_u", 32'(out_last_u), 32'(e[16]));
                    fd_exp_u = e[16];
                end
            end
            if (out_valid_s && out_ready) begin
                if (q_s.size() == 0) check("spurious_s", 32'(out_valid_s), 32'd0);
                else begin
                    logic [16:0] e;
                    e = q_s.pop_front();
                    check("data_s", 32'(out_data_s), 32'(e[15:0]));
                    check("last_s", 32'(out_last_s), 32'(e[16]));
                    fd_exp_s = e[16];
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tot;
        rst       = 1'b1;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready_u), 32'd1);
        check("rst_out_valid", 32'(out_valid_u), 32'd0);
        check("rst_out_data", 32'(out_data_u), 32'd0);
        check("rst_out_last", 32'(out_last_u), 32'd0);
        check("rst_frame_done", 32'(frame_done_u), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Max, unsigned reference frame.
        clear_frame();
        fr[0][0] = 8'h01; fr[0][1] = 8'h02; fr[0][2] = 8'h03; fr[0][3] = 8'h04;
        fr[1][0] = 8'h05; fr[1][1] = 8'h06; fr[1][2] = 8'h07; fr[1][3] = 8'h08;
        run_frame(1'b0, -1, 1'b0);
        drain("max_basic");

        // Average of the same data, then an all-FF frame.
        run_frame(1'b1, -1, 1'b1);
        drain("avg_basic");
        for (int r = 0; r < RS; r++) for (int p = 0; p < RB*L; p++) fr[r][p] = 8'hFF;
        run_frame(1'b1, -1, 1'b1);
        drain("avg_ff");

        // Signed vs unsigned ordering, and signed average of negatives.
        clear_frame();
        fr[0][0] = 8'hFF; fr[0][1] = 8'h01; fr[0][2] = 8'h80; fr[0][3] = 8'h7F;
        fr[1][0] = 8'hFE; fr[1][1] = 8'h00; fr[1][2] = 8'h81; fr[1][3] = 8'h02;
        run_frame(1'b0, -1, 1'b0);
        drain("max_sign");
        clear_frame();
        fr[0][0] = 8'hFF; fr[0][1] = 8'hFF; fr[1][0] = 8'hFF; fr[1][1] = 8'hFE;
        run_frame(1'b1, -1, 1'b1);
        drain("avg_sign");

        // Backpressure: output stalled for 3 cycles after the first odd beat.
        rand_frame();
        expect_frame(1'b0);
        send_range(0, RB, 1'b0, tot);
        out_ready = 1'b0;
        send_range(RB, 1, 1'b0, tot);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready_u), 32'd0);
            check("bp_out_valid", 32'(out_valid_u), 32'd1);
            check("bp_hold_u", 32'(out_data_u), 32'(q_u[0][15:0]));
            check("bp_hold_s", 32'(out_data_s), 32'(q_s[0][15:0]));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_range(RB + 1, RB - 1, 1'b0, tot);
        check("bp_resume_waits", 32'(tot), 32'd0);
        drain("bp");

        // Full throughput with continuous out_ready.
        rand_frame();
        expect_frame(1'b1);
        send_range(0, RS*RB, 1'b1, tot);
        check("throughput_waits", 32'(tot), 32'd0);
        drain("tput");

        // Mode change mid-frame is ignored; next frame picks up the new mode.
        rand_frame();
        run_frame(1'b0, RB + 2, 1'b1);
        drain("mode_hold");
        rand_frame();
        run_frame(1'b1, -1, 1'b1);
        drain("mode_next");

        // Reset at row1 col1 with a pooled beat pending.
        clear_frame();
        fr[0][0] = 8'h01; fr[0][1] = 8'h02; fr[0][2] = 8'h03; fr[0][3] = 8'h04;
        fr[1][0] = 8'h05; fr[1][1] = 8'h06; fr[1][2] = 8'h07; fr[1][3] = 8'h08;
        expect_frame(1'b0);
        send_range(0, RB, 1'b0, tot);
        out_ready = 1'b0;
        send_range(RB, 1, 1'b0, tot);
        @(negedge clk);
        check("pre_rst_out_valid", 32'(out_valid_u), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid_u), 32'd0);
        check("abort_out_last", 32'(out_last_u), 32'd0);
        check("abort_frame_done", 32'(frame_done_u), 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        run_frame(1'b0, -1, 1'b0);
        drain("after_rst");

        // Random frames, back to back, random backpressure.
        bp_rand = 1;
        for (int f = 0; f < 8; f++) begin
            rand_frame();
            run_frame(1'($urandom), (f % 3 == 0) ? int'($urandom_range(1, RS*RB-1)) : -1,
                      1'($urandom));
            bp_rand = 1;
        end
        drain("random");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
